uart_reg_bridge: RTL and testbench

UART_REG_BRIDGE -- requirements
Module: uart_reg_bridge

---
 rtl/uart_bridge_pkg.sv | 23 ++
 rtl/uart_bridge_timer.sv | 31 +++
 rtl/uart_reg_bridge.sv | 167 ++++++++++++++++
 tb/tb_uart_reg_bridge.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared protocol constants, FSM state encoding and byte helpers for the UART register bridge.
// Used by uart_reg_bridge and, when UART_BRIDGE_TIMEOUT_EN is defined, by uart_bridge_timer.
package uart_bridge_pkg;

    localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] RSP_OK    = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR   = 8'h3F;  // '?'

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        REG_READ = 3'd3,
        REG_WAIT = 3'd4,
        SEND     = 3'd5
    } bridge_state_t;

    function automatic logic is_command(input logic [7:0] b);
        return (b == CMD_READ) || (b == CMD_WRITE);
    endfunction

endpackage

// File: rtl/uart_bridge_timer.sv
// Inter-byte timeout counter: counts while run is high, restarts on clear, flags the last cycle.
// Only instantiated when UART_BRIDGE_TIMEOUT_EN is defined.
module uart_bridge_timer #(
    parameter int unsigned CLOCKS_TIMEOUT = 600000
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = (CLOCKS_TIMEOUT > 1) ? $clog2(CLOCKS_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLOCKS_TIMEOUT - 1);

    logic [CW-1:0] count_q;

    // Saturates at LAST so a stalled FSM never sees the counter wrap back to zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear || !run) begin
            count_q <= '0;
        end else if (count_q != LAST) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = run && !clear && (count_q == LAST);

endmodule

// File: rtl/uart_reg_bridge.sv
// Byte-oriented UART command bridge: 'R' addr -> register read, 'W' addr data -> register write.
// Define UART_BRIDGE_TIMEOUT_EN to abort partial commands after CLOCKS_TIMEOUT idle cycles.
//
// Handshakes: rx_valid_i is a single-cycle strobe qualifying rx_data_i; tx_write_o is a
// single-cycle strobe issued only after tx_busy_i was sampled low; reg_read_o and reg_write_o
// are single-cycle strobes with reg_rdata_i expected exactly one cycle after reg_read_o.
module uart_reg_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned CLOCKS_TIMEOUT = 600000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_valid_i,
    output logic [7:0]    tx_data_o,
    output logic          tx_write_o,
    input  logic          tx_busy_i,
    output logic [7:0]    reg_addr_o,
    output logic [7:0]    reg_wdata_o,
    output logic          reg_write_o,
    output logic          reg_read_o,
    input  logic [7:0]    reg_rdata_i,
    output logic          error_o,
    output bridge_state_t state_o
);

    bridge_state_t state_q, state_d;
    logic          is_write_q, is_write_d;
    logic [7:0]    resp_q, resp_d;
    logic [7:0]    tx_data_d, addr_d, wdata_d;
    logic          tx_write_d, reg_write_d, reg_read_d, error_d;
    logic          timeout_hit;

`ifdef UART_BRIDGE_TIMEOUT_EN
    logic timer_run;

    assign timer_run = (state_q == GET_ADDR) || (state_q == GET_DATA);

    uart_bridge_timer #(
        .CLOCKS_TIMEOUT(CLOCKS_TIMEOUT)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .run    (timer_run),
        .clear  (rx_valid_i),
        .expired(timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            is_write_q  <= 1'b0;
            resp_q      <= 8'h00;
            tx_data_o   <= 8'h00;
            tx_write_o  <= 1'b0;
            reg_addr_o  <= 8'h00;
            reg_wdata_o <= 8'h00;
            reg_write_o <= 1'b0;
            reg_read_o  <= 1'b0;
            error_o     <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            resp_q      <= resp_d;
            tx_data_o   <= tx_data_d;
            tx_write_o  <= tx_write_d;
            reg_addr_o  <= addr_d;
            reg_wdata_o <= wdata_d;
            reg_write_o <= reg_write_d;
            reg_read_o  <= reg_read_d;
            error_o     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        resp_d      = resp_q;
        tx_data_d   = tx_data_o;
        addr_d      = reg_addr_o;
        wdata_d     = reg_wdata_o;
        tx_write_d  = 1'b0;
        reg_write_d = 1'b0;
        reg_read_d  = 1'b0;
        error_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_valid_i) begin
                    if (is_command(rx_data_i)) begin
                        is_write_d = (rx_data_i == CMD_WRITE);
                        state_d    = GET_ADDR;
                    end else begin
                        resp_d  = RSP_ERR;
                        error_d = 1'b1;
                        state_d = SEND;
                    end
                end
            end

            GET_ADDR: begin
                if (rx_valid_i) begin
                    addr_d = rx_data_i;
                    if (is_write_q) begin
                        state_d = GET_DATA;
                    end else begin
                        reg_read_d = 1'b1;
                        state_d    = REG_READ;
                    end
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end

            GET_DATA: begin
                if (rx_valid_i) begin
                    wdata_d     = rx_data_i;
                    reg_write_d = 1'b1;
                    resp_d      = RSP_OK;
                    state_d     = SEND;
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end

            REG_READ: begin
                error_d = rx_valid_i;
                state_d = REG_WAIT;
            end

            // Read data goes straight out when the transmitter is free; SEND only absorbs waits.
            REG_WAIT: begin
                error_d = rx_valid_i;
                resp_d  = reg_rdata_i;
                if (!tx_busy_i) begin
                    tx_data_d  = reg_rdata_i;
                    tx_write_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = SEND;
                end
            end

            SEND: begin
                error_d = rx_valid_i;
                if (!tx_busy_i) begin
                    tx_data_d  = resp_q;
                    tx_write_d = 1'b1;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Self-checking bench for uart_reg_bridge: vector table, scoreboard queues, hand-written corner cases.
// Timeout behaviour is checked according to whether UART_BRIDGE_TIMEOUT_EN is defined.
module tb_uart_reg_bridge;
    import uart_bridge_pkg::*;

    localparam int unsigned TIMEOUT = 100;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    rx_data_i;
    logic          rx_valid_i;
    logic [7:0]    tx_data_o;
    logic          tx_write_o;
    logic          tx_busy_i;
    logic [7:0]    reg_addr_o;
    logic [7:0]    reg_wdata_o;
    logic          reg_write_o;
    logic          reg_read_o;
    logic [7:0]    reg_rdata_i;
    logic          error_o;
    bridge_state_t state_o;

    uart_reg_bridge #(.CLOCKS_TIMEOUT(TIMEOUT)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .tx_data_o  (tx_data_o),
        .tx_write_o (tx_write_o),
        .tx_busy_i  (tx_busy_i),
        .reg_addr_o (reg_addr_o),
        .reg_wdata_o(reg_wdata_o),
        .reg_write_o(reg_write_o),
        .reg_read_o (reg_read_o),
        .reg_rdata_i(reg_rdata_i),
        .error_o    (error_o),
        .state_o    (state_o)
    );

    initial forever #5 clock = ~clock;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         nbytes;
        int         busy;
        logic [7:0] exp_tx;
        logic       exp_err;
        logic       exp_wr;
        logic       exp_rd;
    } vec_t;

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_tx_q[$];
    logic [15:0] exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];

    int   tx_cnt = 0, wr_cnt = 0, rd_cnt = 0, err_cnt = 0, cyc = 0;
    int   last_tx_cyc = 0, last_wr_cyc = 0, last_rd_cyc = 0, rx_cyc = 0;
    logic busy_prev = 1'b0;
    logic rd_pending = 1'b0;
    logic [7:0] rd_addr = 8'h00;

    vec_t vecs[11];

    // Peripheral register contents as seen by reads.
    function automatic logic [7:0] reg_model(input logic [7:0] a);
        return a ^ 8'h5C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clock);
        #1;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        rx_cyc     = cyc;
        @(posedge clock);
        #1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'($urandom);
    endtask

    task automatic wait_tx(input int target, input int budget);
        int n;
        n = 0;
        while (tx_cnt < target && n < budget) begin
            @(posedge clock);
            n++;
        end
        #1;
        check("tx_arrival", 32'(tx_cnt >= target), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int e0, t0;
        e0 = err_cnt;
        t0 = tx_cnt;
        exp_tx_q.push_back(v.exp_tx);
        if (v.exp_wr) exp_wr_q.push_back({v.b1, v.b2});
        if (v.exp_rd) exp_rd_q.push_back(v.b1);
        if (v.busy > 0) tx_busy_i = 1'b1;
        send_byte(v.b0);
        if (v.nbytes > 1) send_byte(v.b1);
        if (v.nbytes > 2) send_byte(v.b2);
        if (v.busy > 0) begin
            repeat (v.busy) @(posedge clock);
            #1;
            tx_busy_i = 1'b0;
        end
        wait_tx(t0 + 1, 40);
        repeat (2) @(posedge clock);
        #1;
        check("vec_err_pulses", 32'(err_cnt - e0), 32'(v.exp_err));
        check("vec_tx_count", 32'(tx_cnt - t0), 32'd1);
        check("vec_state_idle", 32'(state_o), 32'(IDLE));
    endtask

    initial begin
        vec_t v;
        int   e0, t0, w0, drop_cyc;
        logic [7:0] b;

        reset       = 1'b1;
        rx_data_i   = 8'h00;
        rx_valid_i  = 1'b0;
        tx_busy_i   = 1'b0;
        reg_rdata_i = 8'h00;

        fork
            forever begin
                @(posedge clock);
                cyc++;
            end
            // Register peripheral: data valid only in the cycle after the read strobe.
            forever begin
                @(posedge clock);
                #1;
                if (rd_pending) begin
                    reg_rdata_i = reg_model(rd_addr);
                    rd_pending  = 1'b0;
                end else begin
                    reg_rdata_i = reg_model(reg_addr_o) ^ 8'($urandom_range(1, 255));
                end
            end
            // Output monitor and scoreboard.
            forever begin
                @(negedge clock);
                if (!reset) begin
                    if (error_o) err_cnt++;
                    if (tx_write_o) begin
                        tx_cnt++;
                        last_tx_cyc = cyc;
                        check("tx_while_busy", 32'(busy_prev), 32'd0);
                        check("tx_expected", 32'(exp_tx_q.size() != 0), 32'd1);
                        if (exp_tx_q.size() != 0) check("tx_data", 32'(tx_data_o), 32'(exp_tx_q.pop_front()));
                    end
                    if (reg_write_o) begin
                        wr_cnt++;
                        last_wr_cyc = cyc;
                        check("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
                        if (exp_wr_q.size() != 0) check("wr_addr_data", 32'({reg_addr_o, reg_wdata_o}), 32'(exp_wr_q.pop_front()));
                    end
                    if (reg_read_o) begin
                        rd_cnt++;
                        last_rd_cyc = cyc;
                        rd_pending  = 1'b1;
                        rd_addr     = reg_addr_o;
                        check("rd_expected", 32'(exp_rd_q.size() != 0), 32'd1);
                        if (exp_rd_q.size() != 0) check("rd_addr", 32'(reg_addr_o), 32'(exp_rd_q.pop_front()));
                    end
                    if (reg_read_o || reg_write_o) check("rd_wr_exclusive", 32'(reg_read_o & reg_write_o), 32'd0);
                end
                busy_prev = tx_busy_i;
            end
        join_none

        vecs[0]  = '{8'h57, 8'h10, 8'hA5, 3, 0, 8'h4B, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{8'h52, 8'h22, 8'h00, 2, 0, 8'h7E, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{8'h41, 8'h00, 8'h00, 1, 0, 8'h3F, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{8'h57, 8'hFF, 8'h00, 3, 0, 8'h4B, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{8'h52, 8'h00, 8'h00, 2, 0, reg_model(8'h00), 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{8'h52, 8'hFF, 8'h00, 2, 0, reg_model(8'hFF), 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{8'h00, 8'h00, 8'h00, 1, 0, 8'h3F, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{8'hFF, 8'h00, 8'h00, 1, 0, 8'h3F, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{8'h72, 8'h00, 8'h00, 1, 0, 8'h3F, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{8'h57, 8'h80, 8'h5A, 3, 3, 8'h4B, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{8'h52, 8'h3C, 8'h00, 2, 5, reg_model(8'h3C), 1'b0, 1'b0, 1'b1};

        // Reset state: everything low while reset is held.
        repeat (3) @(posedge clock);
        #1;
        check("rst_outputs", 32'({tx_data_o, reg_addr_o, reg_wdata_o}), 32'd0);
        check("rst_strobes", 32'({tx_write_o, reg_write_o, reg_read_o, error_o}), 32'd0);
        check("rst_state", 32'(state_o), 32'(IDLE));
        reset = 1'b0;
        repeat (2) @(posedge clock);

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i]);
            if (i == 0) begin
                check("wr_strobe_latency", 32'(last_wr_cyc - rx_cyc), 32'd1);
                check("wr_tx_latency", 32'(last_tx_cyc - rx_cyc), 32'd2);
                check("hold_addr_after_wr", 32'(reg_addr_o), 32'h10);
                check("hold_wdata_after_wr", 32'(reg_wdata_o), 32'hA5);
                check("hold_tx_after_wr", 32'(tx_data_o), 32'h4B);
            end
            if (i == 1) begin
                check("rd_strobe_latency", 32'(last_rd_cyc - rx_cyc), 32'd1);
                check("rd_tx_latency", 32'(last_tx_cyc - rx_cyc), 32'd3);
                check("hold_wdata_after_rd", 32'(reg_wdata_o), 32'hA5);
                check("hold_tx_after_rd", 32'(tx_data_o), 32'h7E);
            end
        end

        for (int i = 0; i < 16; i++) begin
            v.busy = 0;
            v.b1   = 8'($urandom_range(0, 255));
            v.b2   = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0: begin
                    v.b0 = CMD_WRITE; v.nbytes = 3; v.exp_tx = RSP_OK;
                    v.exp_err = 1'b0; v.exp_wr = 1'b1; v.exp_rd = 1'b0;
                end
                1: begin
                    v.b0 = CMD_READ; v.nbytes = 2; v.exp_tx = reg_model(v.b1);
                    v.exp_err = 1'b0; v.exp_wr = 1'b0; v.exp_rd = 1'b1;
                end
                default: begin
                    b = 8'($urandom_range(0, 255));
                    if (is_command(b)) b = b ^ 8'h01;
                    v.b0 = b; v.nbytes = 1; v.exp_tx = RSP_ERR;
                    v.exp_err = 1'b1; v.exp_wr = 1'b0; v.exp_rd = 1'b0;
                end
            endcase
            run_vec(v);
        end

        // Read with transmitter busy for 500 cycles and a stray byte during the wait.
        t0 = tx_cnt;
        exp_tx_q.push_back(8'h7E);
        exp_rd_q.push_back(8'h22);
        tx_busy_i = 1'b1;
        send_byte(8'h52);
        send_byte(8'h22);
        repeat (100) @(posedge clock);
        e0 = err_cnt;
        send_byte(8'h99);
        repeat (400) @(posedge clock);
        #1;
        check("busy_stray_err", 32'(err_cnt - e0), 32'd1);
        check("busy_no_tx", 32'(tx_cnt - t0), 32'd0);
        check("busy_state_send", 32'(state_o), 32'(SEND));
        tx_busy_i = 1'b0;
        drop_cyc  = cyc;
        wait_tx(t0 + 1, 10);
        check("busy_release_latency", 32'(last_tx_cyc - drop_cyc), 32'd1);
        repeat (5) @(posedge clock);
        #1;
        check("busy_tx_once", 32'(tx_cnt - t0), 32'd1);

        // Stray byte arriving in the same cycle the transmitter frees up.
        t0 = tx_cnt;
        exp_tx_q.push_back(RSP_OK);
        exp_wr_q.push_back(16'h30C3);
        tx_busy_i = 1'b1;
        send_byte(8'h57);
        send_byte(8'h30);
        send_byte(8'hC3);
        repeat (10) @(posedge clock);
        #1;
        e0         = err_cnt;
        rx_data_i  = 8'h52;
        rx_valid_i = 1'b1;
        tx_busy_i  = 1'b0;
        drop_cyc   = cyc;
        @(posedge clock);
        #1;
        rx_valid_i = 1'b0;
        wait_tx(t0 + 1, 10);
        repeat (3) @(posedge clock);
        #1;
        check("same_cycle_tx_latency", 32'(last_tx_cyc - drop_cyc), 32'd1);
        check("same_cycle_err", 32'(err_cnt - e0), 32'd1);
        check("same_cycle_tx_once", 32'(tx_cnt - t0), 32'd1);
        check("same_cycle_idle", 32'(state_o), 32'(IDLE));

        // Reset in the middle of a write discards it.
        t0 = tx_cnt;
        w0 = wr_cnt;
        send_byte(8'h57);
        send_byte(8'h10);
        check("pre_reset_addr", 32'(reg_addr_o), 32'h10);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_outputs", 32'({tx_data_o, reg_addr_o, reg_wdata_o}), 32'd0);
        check("async_rst_state", 32'(state_o), 32'(IDLE));
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check("post_rst_no_wr", 32'(wr_cnt - w0), 32'd0);
        check("post_rst_no_tx", 32'(tx_cnt - t0), 32'd0);
        run_vec('{8'h52, 8'h10, 8'h00, 2, 0, reg_model(8'h10), 1'b0, 1'b0, 1'b1});

        // Partial command followed by a long silence.
        e0 = err_cnt;
        t0 = tx_cnt;
        send_byte(8'h57);
        repeat (150) @(posedge clock);
        #1;
`ifdef UART_BRIDGE_TIMEOUT_EN
        check("timeout_err", 32'(err_cnt - e0), 32'd1);
        check("timeout_idle", 32'(state_o), 32'(IDLE));
        check("timeout_no_tx", 32'(tx_cnt - t0), 32'd0);
`else
        check("no_timeout_err", 32'(err_cnt - e0), 32'd0);
        check("no_timeout_waiting", 32'(state_o), 32'(GET_ADDR));
        exp_tx_q.push_back(RSP_OK);
        exp_wr_q.push_back(16'h0102);
        send_byte(8'h01);
        send_byte(8'h02);
        wait_tx(t0 + 1, 20);
`endif
        run_vec('{8'h52, 8'h01, 8'h00, 2, 0, reg_model(8'h01), 1'b0, 1'b0, 1'b1});

        check("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);
        check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
